// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout and register constants.
// Used by id_ex_stage and hazard_detect.
package mips_pipe_pkg;

    // Control bundle layout, MSB first:
    // RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0], Branch
    localparam int CTRL_W        = 9;
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_ALUOP0   = 1;
    localparam int CTRL_ALUOP1   = 2;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_REGWRITE = 8;

    // $zero is hardwired and never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Writeback-to-decode bypass: take the value being written back when it
    // targets the register being read in this same cycle.
    function automatic logic [31:0] wb_select(
        input logic        wb_we,
        input logic [4:0]  wb_reg,
        input logic [31:0] wb_data,
        input logic [4:0]  rd_reg,
        input logic [31:0] rd_data
    );
        if (wb_we && (wb_reg != REG_ZERO) && (wb_reg == rd_reg))
            return wb_data;
        return rd_data;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare between the load in
// EX and the instruction sitting in decode.
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       stall
);

    // A load whose destination is $zero never creates a dependency.
    always_comb begin
        stall = 1'b0;
        if (ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && id_valid &&
            ((ex_rt == id_rs) || (ex_rt == id_rt)))
            stall = 1'b1;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubble and
// saturating stall counter.
// Optional macro ID_EX_WB_BYPASS_EN: forward the writeback write port into
// the registered operands when it targets IdRs/IdRt in the same cycle.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   IdValid,
    input  logic [4:0]             IdRs,
    input  logic [4:0]             IdRt,
    input  logic [4:0]             IdRd,
    input  logic [31:0]            IdReadData1,
    input  logic [31:0]            IdReadData2,
    input  logic [31:0]            IdImm,
    input  logic [CTRL_W-1:0]      IdCtrl,
    input  logic                   Flush,
    input  logic                   WbRegWrite,
    input  logic [4:0]             WbWriteReg,
    input  logic [31:0]            WbWriteData,
    output logic                   ExValid,
    output logic [4:0]             ExRs,
    output logic [4:0]             ExRt,
    output logic [4:0]             ExDestReg,
    output logic [31:0]            ExData1,
    output logic [31:0]            ExData2,
    output logic [31:0]            ExImm,
    output logic [CTRL_W-1:0]      ExCtrl,
    output logic                   Stall,
    output logic [STALL_CNT_W-1:0] StallCount
);

    logic                   ex_valid_q,  ex_valid_d;
    logic [4:0]             ex_rs_q,     ex_rs_d;
    logic [4:0]             ex_rt_q,     ex_rt_d;
    logic [4:0]             ex_dest_q,   ex_dest_d;
    logic [31:0]            ex_data1_q,  ex_data1_d;
    logic [31:0]            ex_data2_q,  ex_data2_d;
    logic [31:0]            ex_imm_q,    ex_imm_d;
    ctrl_t                  ex_ctrl_q,   ex_ctrl_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        stall;
    logic [31:0] op1;
    logic [31:0] op2;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rt       (ex_rt_q),
        .id_valid    (IdValid),
        .id_rs       (IdRs),
        .id_rt       (IdRt),
        .stall       (stall)
    );

`ifdef ID_EX_WB_BYPASS_EN
    // Operand select with writeback bypass.
    always_comb begin
        op1 = wb_select(WbRegWrite, WbWriteReg, WbWriteData, IdRs, IdReadData1);
        op2 = wb_select(WbRegWrite, WbWriteReg, WbWriteData, IdRt, IdReadData2);
    end
`else
    logic unused_wb;
    assign unused_wb = ^{WbRegWrite, WbWriteReg, WbWriteData};

    // Operands pass straight from the register file.
    always_comb begin
        op1 = IdReadData1;
        op2 = IdReadData2;
    end
`endif

    // Next-state: bubble on flush, stall or empty decode; otherwise capture
    // the decoded instruction. A bubble keeps the data fields unchanged.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_dest_d  = ex_dest_q;
        ex_data1_d = ex_data1_q;
        ex_data2_d = ex_data2_q;
        ex_imm_d   = ex_imm_q;
        if (!Flush && !stall && IdValid) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = IdCtrl;
            ex_rs_d    = IdRs;
            ex_rt_d    = IdRt;
            ex_dest_d  = IdCtrl[CTRL_REGDST] ? IdRd : IdRt;
            ex_data1_d = op1;
            ex_data2_d = op2;
            ex_imm_d   = IdImm;
        end
    end

    // Stall counter: a flushed stall cycle is not counted; holds at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !Flush && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State registers; reset clears every field including data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_dest_q   <= '0;
            ex_data1_q  <= '0;
            ex_data2_q  <= '0;
            ex_imm_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_dest_q   <= ex_dest_d;
            ex_data1_q  <= ex_data1_d;
            ex_data2_q  <= ex_data2_d;
            ex_imm_q    <= ex_imm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ExValid    = ex_valid_q;
    assign ExCtrl     = ex_ctrl_q;
    assign ExRs       = ex_rs_q;
    assign ExRt       = ex_rt_q;
    assign ExDestReg  = ex_dest_q;
    assign ExData1    = ex_data1_q;
    assign ExData2    = ex_data2_q;
    assign ExImm      = ex_imm_q;
    assign Stall      = stall;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [8:0] C_LW  = 9'b1_1_0_1_1_0_00_0; // RegWrite MemRead MemToReg ALUSrc
    localparam logic [8:0] C_ADD = 9'b1_0_0_0_0_1_10_0; // RegWrite RegDst ALUOp=10
    localparam logic [8:0] C_ADDI= 9'b1_0_0_0_1_0_00_0; // RegWrite ALUSrc

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [31:0]       id_d1, id_d2, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic              wb_we;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              ex_valid;
    logic [4:0]        ex_rs, ex_rt, ex_dest;
    logic [31:0]       ex_d1, ex_d2, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall;
    logic [CW-1:0]     stall_count;

    int total = 0;
    int bad   = 0;

    // Model state: what the EX register should hold.
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [8:0]  m_ctrl;
    int          m_cnt;

    id_ex_stage #(.STALL_CNT_W(CW)) dut (
        .Clk(clk), .Reset(rst), .IdValid(id_valid),
        .IdRs(id_rs), .IdRt(id_rt), .IdRd(id_rd),
        .IdReadData1(id_d1), .IdReadData2(id_d2), .IdImm(id_imm),
        .IdCtrl(id_ctrl), .Flush(flush),
        .WbRegWrite(wb_we), .WbWriteReg(wb_reg), .WbWriteData(wb_data),
        .ExValid(ex_valid), .ExRs(ex_rs), .ExRt(ex_rt), .ExDestReg(ex_dest),
        .ExData1(ex_d1), .ExData2(ex_d2), .ExImm(ex_imm), .ExCtrl(ex_ctrl),
        .Stall(stall), .StallCount(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Hazard rule in plain terms: a valid load in EX writing a non-zero
    // register that the decode instruction reads.
    function automatic logic model_stall();
        return m_valid && m_ctrl[CTRL_MEMREAD] && (m_rt != 5'd0) && id_valid &&
               ((m_rt == id_rs) || (m_rt == id_rt));
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] r, input logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_we && wb_reg != 5'd0 && wb_reg == r) return wb_data;
`endif
        return rf;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        chk("ExValid",   {31'd0, ex_valid}, {31'd0, m_valid});
        chk("ExCtrl",    {23'd0, ex_ctrl},  {23'd0, m_ctrl});
        chk("ExRs",      {27'd0, ex_rs},    {27'd0, m_rs});
        chk("ExRt",      {27'd0, ex_rt},    {27'd0, m_rt});
        chk("ExDestReg", {27'd0, ex_dest},  {27'd0, m_dest});
        chk("ExData1",   ex_d1, m_d1);
        chk("ExData2",   ex_d2, m_d2);
        chk("ExImm",     ex_imm, m_imm);
        chk("StallCount",{28'd0, stall_count}, m_cnt);
    endtask

    // One clock: check combinational Stall, advance DUT and model, compare.
    task automatic step();
        logic s;
        logic [31:0] o1, o2;
        #1;
        s  = model_stall();
        o1 = model_operand(id_rs, id_d1);
        o2 = model_operand(id_rt, id_d2);
        chk("Stall", {31'd0, stall}, {31'd0, s});
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (s && !flush && m_cnt < CNT_MAX) m_cnt++;
            if (flush || s || !id_valid) begin
                m_valid = 0;
                m_ctrl  = 0;
            end else begin
                m_valid = 1;
                m_ctrl  = id_ctrl;
                m_rs    = id_rs;
                m_rt    = id_rt;
                m_dest  = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
                m_d1    = o1;
                m_d2    = o2;
                m_imm   = id_imm;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [8:0] c, input logic f);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = c; flush = f;
        id_d1 = $urandom; id_d2 = $urandom; id_imm = $urandom;
    endtask

    typedef struct {
        logic       vld;
        logic [4:0] rs, rt, rd;
        logic [8:0] ctrl;
        logic       flush;
        logic       exp_stall;
        logic       exp_valid;
        logic [4:0] exp_dest;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Directed sequence: load-use, $zero loads, flush+stall, RegDst, empty decode.
        vecs[0] = '{1, 1,  5, 0,  C_LW,   0, 0, 1, 5};
        vecs[1] = '{1, 5,  6, 7,  C_ADD,  0, 1, 0, 5};
        vecs[2] = '{1, 5,  6, 7,  C_ADD,  0, 0, 1, 7};
        vecs[3] = '{1, 2,  0, 0,  C_LW,   0, 0, 1, 0};
        vecs[4] = '{1, 0,  0, 9,  C_ADD,  0, 0, 1, 9};
        vecs[5] = '{1, 0,  8, 0,  C_LW,   0, 0, 1, 8};
        vecs[6] = '{1, 3,  8, 4,  C_ADD,  1, 1, 0, 8};
        vecs[7] = '{1, 1,  3, 12, C_ADD,  0, 0, 1, 12};
        vecs[8] = '{1, 1,  3, 12, C_ADDI, 0, 0, 1, 3};
        vecs[9] = '{0, 3,  3, 3,  C_LW,   0, 0, 0, 3};

        rst = 1; wb_we = 0; wb_reg = 0; wb_data = 0;
        set_id(0, 0, 0, 0, 0, 0);
        model_clear();
        @(posedge clk); #1;
        step();                 // still in reset
        rst = 0;
        check_outputs();        // reset state
        chk("Stall after reset", {31'd0, stall}, 32'd0);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            set_id(vecs[i].vld, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ctrl, vecs[i].flush);
            #1;
            chk($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            step();
            chk($sformatf("vec%0d valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].exp_dest});
            if (!vecs[i].exp_valid)
                chk($sformatf("vec%0d ctrl", i), {23'd0, ex_ctrl}, 32'd0);
        end
        chk("count after table", {28'd0, stall_count}, 32'd1);

        // Writeback bypass case.
        set_id(1, 7, 2, 0, C_ADDI, 0);
        id_d1 = 32'h0; wb_we = 1; wb_reg = 7; wb_data = 32'hDEADBEEF;
        step();
`ifdef ID_EX_WB_BYPASS_EN
        chk("bypass hit", ex_d1, 32'hDEADBEEF);
`else
        chk("bypass off", ex_d1, 32'h0);
`endif
        set_id(1, 7, 2, 0, C_ADDI, 0);
        id_d1 = 32'h0; wb_reg = 0;
        step();
        chk("bypass reg0", ex_d1, 32'h0);
        wb_we = 0;

        // Randomized traffic with small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), 9'($urandom), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) id_ctrl[CTRL_MEMREAD] = 1'b1;
            wb_we   = 1'($urandom);
            wb_reg  = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            step();
        end
        wb_we = 0;

        // Saturation: 20 counted stalls into a 4-bit counter.
        rst = 1;
        step();
        rst = 0;
        chk("count cleared", {28'd0, stall_count}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            set_id(1, 1, 5, 0, C_LW, 0);
            step();
            set_id(1, 5, 6, 7, C_ADD, 0);
            chk("sat stall", {31'd0, stall}, 32'd1);
            step();
        end
        chk("count saturated", {28'd0, stall_count}, 32'd15);

        // One reset cycle clears everything.
        set_id(1, 9, 10, 11, C_ADD, 0);
        rst = 1;
        step();
        rst = 0;
        chk("rst valid", {31'd0, ex_valid}, 32'd0);
        chk("rst ctrl",  {23'd0, ex_ctrl}, 32'd0);
        chk("rst rs",    {27'd0, ex_rs}, 32'd0);
        chk("rst rt",    {27'd0, ex_rt}, 32'd0);
        chk("rst dest",  {27'd0, ex_dest}, 32'd0);
        chk("rst d1",    ex_d1, 32'd0);
        chk("rst d2",    ex_d2, 32'd0);
        chk("rst imm",   ex_imm, 32'd0);
        chk("rst count", {28'd0, stall_count}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, giving the width of the load-use stall counter.
REQ-002 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 SHALL have port IdValid  input  1  the decode stage holds a valid instruction.
REQ-005 SHALL have ports IdRs, IdRt, IdRd  input  5 each  decoded register specifiers.
REQ-006 SHALL have ports IdReadData1, IdReadData2  input  32 each  register file read data for Rs and Rt.
REQ-007 SHALL have port IdImm  input  32  sign-extended immediate.
REQ-008 SHALL have port IdCtrl  input  CTRL_W (9)  control bundle: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0], Branch.
REQ-009 SHALL have port Flush  input  1  taken branch or jump; kill the instruction in decode.
REQ-010 SHALL have ports WbRegWrite (1), WbWriteReg (5), WbWriteData (32)  input  writeback-stage write port.
REQ-011 SHALL have ports ExValid (1), ExRs (5), ExRt (5), ExDestReg (5), ExData1 (32), ExData2 (32), ExImm (32), ExCtrl (CTRL_W)  output  registered execute-stage operands.
REQ-012 SHALL have port Stall  output  1  combinational load-use hazard; freezes the PC and IF/ID register.
REQ-013 SHALL have port StallCount  output  STALL_CNT_W  saturating count of stall cycles.

Function
REQ-014 SHALL register all Ex* outputs on each rising Clk edge, giving a latency of 1 cycle from Id* to Ex*.
REQ-015 SHALL drive ExDestReg with IdRd when the IdCtrl RegDst bit is 1, and with IdRt otherwise.
REQ-016 SHALL assert Stall when ExValid=1, the ExCtrl MemRead bit is 1, ExRt != 0, IdValid=1, and ExRt equals IdRs or IdRt.
REQ-017 SHALL load a bubble on a Stall cycle: ExValid=0 and ExCtrl=0, with the other Ex* outputs holding their previous values.
REQ-018 SHALL load a bubble on a Flush cycle, and Flush SHALL take priority over Stall.
REQ-019 SHALL load a bubble when IdValid=0.
REQ-020 SHALL never produce two consecutive Stall cycles for the same instruction, because the bubble clears MemRead.
REQ-021 SHALL increment StallCount by 1 in each cycle where Stall=1 and Flush=0, saturating at all-ones without wrapping.
REQ-022 SHALL let an IdRs or IdRt value of 0 participate in the Stall compare only through ExRt != 0; an ExRt of 0 SHALL never cause a stall.

Reset
REQ-023 SHALL, when Reset=1 at a rising edge, clear ExValid, ExCtrl, ExRs, ExRt, ExDestReg, ExData1, ExData2, ExImm and StallCount to 0.
REQ-024 SHALL hold Stall at 0 during any cycle in which ExValid=0, which covers the first cycle after reset.
REQ-025 SHALL give Reset priority over Flush, Stall and every data input.

Configuration
REQ-026 SHALL, with macro ID_EX_WB_BYPASS_EN defined, use WbWriteData in place of IdReadData1 when WbRegWrite=1, WbWriteReg != 0 and WbWriteReg == IdRs; the same rule SHALL apply to IdReadData2 with IdRt.
REQ-027 SHALL, without ID_EX_WB_BYPASS_EN, register IdReadData1 and IdReadData2 unmodified, and the Wb* ports SHALL be ignored.

Structure
REQ-028 SHALL take CTRL_W, the control-bit index constants (CTRL_REGWRITE ... CTRL_BRANCH) and REG_ZERO from the shared package mips_pipe_pkg.
REQ-029 SHALL place the load-use compare of REQ-016 and REQ-022 in the combinational sub-module hazard_detect, instantiated once.

Verification
REQ-030 SHALL cover: lw $5 in EX with MemRead=1, ExRt=5; decode add IdRs=5 -> Stall=1; next cycle ExValid=0, ExCtrl=0; following cycle Stall=0 and the add is registered.
REQ-031 SHALL cover: ExRt=0 with MemRead=1 and IdRs=0 -> Stall=0, and StallCount is unchanged.
REQ-032 SHALL cover: Flush=1 and Stall=1 in the same cycle -> bubble loaded; StallCount is not incremented.
REQ-033 SHALL cover (bypass on): WbRegWrite=1, WbWriteReg=7, WbWriteData=0xDEADBEEF, IdRs=7, IdReadData1=0x0 -> ExData1=0xDEADBEEF; with WbWriteReg=0 -> ExData1=0x0.
REQ-034 SHALL cover: STALL_CNT_W=4, 20 stall cycles -> StallCount=15; then Reset=1 for one cycle -> all outputs 0.
REQ-035 SHALL cover: RegDst=1, IdRd=12, IdRt=3 -> ExDestReg=12; RegDst=0 -> ExDestReg=3.
